// File: rtl/stream_mux_rr.sv
// stream_mux_rr: NUM_CH valid/ready input streams multiplexed onto one
// registered output stream. Channel choice is round-robin (mode=0) or a
// fixed select (mode=1), decided combinationally every cycle. A saturating
// counter tracks output beats consumed downstream.
//
// Handshake: a beat moves across any interface on a rising edge where both
// valid and ready are high. Producers hold valid and data until accepted.
// in_ready is combinational and may only rise for the granted channel when
// the output register can take a new beat (empty, or draining this cycle).
// out_valid/out_data/out_ch are registered and held stable while
// out_valid && !out_ready.
module stream_mux_rr #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        xfer_cnt
);

    // Output stage and arbitration state
    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_ch;
    logic              r_out_valid;
    logic [SEL_W-1:0]  r_last_grant;
    logic [CNT_W-1:0]  r_xfer_cnt;

    // Arbitration results
    logic              w_grant_any;
    int                w_grant_idx;
    logic              w_load_en;
    logic              w_accept;
    logic [WIDTH-1:0]  w_sel_data;

    // Grant selection: rotating search after the last winner, or fixed sel
    always_comb begin
        int                c;
        int                s;
        logic [NUM_CH-1:0] v;
        w_grant_any = 1'b0;
        w_grant_idx = 0;
        c           = 0;
        s           = 0;
        v           = '0;
        if (!mode) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                c = int'(r_last_grant) + k;
                if (c >= NUM_CH) begin
                    c = c - NUM_CH;
                end
                v = in_valid >> c;
                if (!w_grant_any && v[0]) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = c;
                end
            end
        end else begin
            // Out-of-range sel simply never grants
            s = int'(sel);
            if (s < NUM_CH) begin
                v = in_valid >> s;
                if (v[0]) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = s;
                end
            end
        end
    end

    // Load enable, handshake and granted-channel data selection
    always_comb begin
        w_load_en  = !r_out_valid || out_ready;
        w_accept   = rst_n && w_load_en && w_grant_any;
        in_ready   = w_accept ? (NUM_CH'(1) << w_grant_idx) : '0;
        w_sel_data = WIDTH'(in_data >> (w_grant_idx * WIDTH));
    end

    // Output register, last-grant pointer and saturating beat counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data   <= '0;
            r_out_ch     <= '0;
            r_out_valid  <= 1'b0;
            r_last_grant <= SEL_W'(NUM_CH - 1);
            r_xfer_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_out_data   <= w_sel_data;
                r_out_ch     <= SEL_W'(w_grant_idx);
                r_out_valid  <= 1'b1;
                r_last_grant <= SEL_W'(w_grant_idx);
            end else if (r_out_valid && out_ready) begin
                // Drained with nothing to refill: data/ch keep last values
                r_out_valid <= 1'b0;
            end
            if (r_out_valid && out_ready && (r_xfer_cnt != {CNT_W{1'b1}})) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign xfer_cnt  = r_xfer_cnt;

endmodule
